norm_arbiter: RTL and testbench

Round-robin scheduler sharing one L1-magnitude datapath (|re| + |im|) among NREQ requesters, such as per-level partial-distance units of the sphere-decoder search tree. Accepts one complex operand per cycle with valid/ready handshakes, computes its magnitude in a two-stage pipeline and returns it tagged with the requester index. Also returns a prune flag from comparison against the current sphere radius.

---
 rtl/norm_arbiter.sv | 129 ++++++++++++
 tb/tb_norm_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin arbiter feeding a two-stage |re|+|im| pipeline with radius prune flag.
// Optional macro NORM_SAT_EN: saturate the magnitude sum instead of wrapping.
`default_nettype none

module norm_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      radius,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_real,
  input  logic [NREQ*WIDTH-1:0] req_imag,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_norm,
  output logic [IDW-1:0]        out_id,
  output logic                  out_prune
);

  logic [IDW-1:0]   ptr;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_re;
  logic [WIDTH-1:0] s1_im;
  logic [WIDTH-1:0] s1_rad;
  logic [IDW-1:0]   s1_id;

  logic             found;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] sel_re;
  logic [WIDTH-1:0] sel_im;
  logic             s2_adv;
  logic             load_ok;
  logic             accept;
  logic [WIDTH-1:0] abs_re;
  logic [WIDTH-1:0] abs_im;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] norm;
  logic             prune;

  // Scan from ptr upward; IDW-bit index arithmetic wraps mod NREQ for free.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[ptr + IDW'(k)]) begin
        found = 1'b1;
        win   = ptr + IDW'(k);
      end
    end
  end

  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_re = req_real[i*WIDTH +: WIDTH];
        sel_im = req_imag[i*WIDTH +: WIDTH];
      end
    end
  end

  assign s2_adv  = !out_valid || out_ready;
  // rst_n gates the grant so req_ready reads zero throughout reset.
  assign load_ok = (!s1_valid || s2_adv) && !flush && rst_n;
  assign accept  = found && load_ok;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign abs_re = s1_re[WIDTH-1] ? (~s1_re + WIDTH'(1)) : s1_re;
  assign abs_im = s1_im[WIDTH-1] ? (~s1_im + WIDTH'(1)) : s1_im;
  assign sum    = {1'b0, abs_re} + {1'b0, abs_im};

`ifdef NORM_SAT_EN
  assign norm = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign norm = sum[WIDTH-1:0];
`endif

  assign prune = norm > s1_rad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_rad    <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_norm  <= '0;
      out_id    <= '0;
      out_prune <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_norm  <= norm;
          out_id    <= s1_id;
          out_prune <= prune;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_re    <= sel_re;
        s1_im    <= sel_im;
        s1_rad   <= radius;
        s1_id    <= win;
        ptr      <= win + IDW'(1);
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_norm_arbiter.sv
// Scoreboard bench for norm_arbiter: directed stimulus pushes expected results, a monitor pops them.
`default_nettype none

module tb_norm_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [WIDTH-1:0]      radius;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_real;
  logic [NREQ*WIDTH-1:0] req_imag;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_norm;
  logic [IDW-1:0]        out_id;
  logic                  out_prune;

  norm_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .radius(radius),
    .req_valid(req_valid), .req_real(req_real), .req_imag(req_imag),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_norm(out_norm), .out_id(out_id), .out_prune(out_prune)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] norm;
    logic [IDW-1:0]   id;
    logic             prune;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] n, input int id, input logic p);
    exp_t e;
    e.norm  = n;
    e.id    = IDW'(id);
    e.prune = p;
    q.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
    req_real[i*WIDTH +: WIDTH] = re;
    req_imag[i*WIDTH +: WIDTH] = im;
  endtask

  // One cycle; accepted requesters drop their valid after the edge.
  task automatic step_clr();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {30'd0, out_id, out_norm}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_norm",  64'(out_norm),  64'(e.norm));
        chk("out_id",    64'(out_id),    64'(e.id));
        chk("out_prune", 64'(out_prune), 64'(e.prune));
      end
    end
  end

  initial begin
    int nacc;
    int t;
    logic [NREQ-1:0] acc;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    req_real = '0; req_imag = '0;
    radius = 32'd10;
    set_op(2, -32'sd5, 32'sd7);
    req_valid = 4'b0100;

    // Reset state with a request pending
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_norm",  64'(out_norm),  64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    chk("rst_out_prune", 64'(out_prune), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single operand from requester 2: 5 + 7 = 12 > 10
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'h4);
    push(32'd12, 2, 1'b1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t1_lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_lat", 64'(out_valid), 64'd1);
    drain(2);

    // Continuous stream, ptr starts at 3; req i norm = 5i+1, radius 8
    radius = 32'd8;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(3*i + 1), -32'(2*i));
    req_valid = 4'b1111;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      chk("t2_grant", 64'(req_ready), 64'(1 << ((3 + n) % 4)));
      push(32'(5*((3 + n) % 4) + 1), (3 + n) % 4, ((3 + n) % 4) >= 2);
      if (n >= 2) chk("t2_thru", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain(4);

    // Backpressure: ptr = 0, requesters 1 and 3, requester 0 joins late
    out_ready = 1'b0;
    radius = 32'd120;
    set_op(1, 32'sd100, -32'sd50);
    set_op(3, -32'sd1, -32'sd1);
    set_op(0, 32'sd4, 32'sd4);
    push(32'd150, 1, 1'b1);
    push(32'd2, 3, 1'b0);
    push(32'd8, 0, 1'b0);
    req_valid = 4'b1010;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("t3_ready_blocked", 64'(req_ready), 64'd0);
        chk("t3_hold_valid", 64'(out_valid), 64'd1);
        chk("t3_hold_norm",  64'(out_norm),  64'd150);
        chk("t3_hold_id",    64'(out_id),    64'd1);
      end
      acc = req_valid & req_ready;
      nacc += $countones(acc);
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      if (c == 1) req_valid[0] = 1'b1;
    end
    chk("t3_accepts", 64'(nacc), 64'd2);
    out_ready = 1'b1;
    repeat (4) step_clr();
    drain(3);

    // Most negative operands, ptr = 1 -> requester 2 only
    radius = 32'd0;
    set_op(2, 32'h8000_0000, 32'h8000_0000);
`ifdef NORM_SAT_EN
    push(32'hFFFF_FFFF, 2, 1'b1);
`else
    push(32'h0000_0000, 2, 1'b0);
`endif
    req_valid = 4'b0100;
    repeat (3) step_clr();
    drain(3);

    // Flush with both stages full, ptr = 3
    out_ready = 1'b0;
    radius = 32'd100;
    set_op(3, 32'sd10, 32'sd10);
    set_op(0, 32'sd1, 32'sd1);
    req_valid = 4'b1001;
    step_clr();
    step_clr();
    @(negedge clk);
    chk("t5_full", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    radius = 32'd6;
    set_op(1, -32'sd3, -32'sd4);
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t5_flush_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_flushed", 64'(out_valid), 64'd0);
    chk("t5_ptr_held", 64'(req_ready), 64'h2);
    push(32'd7, 1, 1'b1);
    @(posedge clk); #1 req_valid = '0;
    out_ready = 1'b1;
    drain(4);

    // Asynchronous reset with the pipeline full, ptr = 2
    out_ready = 1'b0;
    set_op(2, 32'sd5, 32'sd5);
    set_op(3, 32'sd6, 32'sd6);
    req_valid = 4'b1100;
    step_clr();
    step_clr();
    req_valid = 4'b1111;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_norm",  64'(out_norm),  64'd0);
    chk("t6_out_id",    64'(out_id),    64'd0);
    chk("t6_out_prune", 64'(out_prune), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    radius = 32'd6;
    set_op(0, 32'sd2, -32'sd3);
    @(negedge clk);
    chk("t6_ptr_reset", 64'(req_ready), 64'h1);
    push(32'd5, 0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 req_valid = '0;

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
